serial_add_ctrl: RTL

//  Bit-serial adder controller: time-shares one 1-bit full-adder cell across WIDTH cycles
//  to add two WIDTH-bit operands, LSB first, with a registered carry between cycles.

---
 rtl/serial_add_pkg.sv | 25 ++
 rtl/bit_full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and count sizing.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bit_full_adder.sv
// Single 1-bit full-adder cell shared across all bit positions of the serial add.
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s1,
  output logic s0
);

  assign s0 = a ^ b ^ cin;
  assign s1 = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, LSB first, WIDTH cycles per add.
// Optional subtract mode is enabled with the SERIAL_ADD_SUB_EN macro.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_r;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-2:0]   res_r;
  logic [WIDTH-1:0]   res_nxt;
  logic [CNT_W-1:0]   count_r;
  logic               carry_r;
  logic               load_s;
  logic               last_s;
  logic               cin_s;
  logic [WIDTH-1:0]   b_load_s;
  logic               s1_s;
  logic               s0_s;

`ifdef SERIAL_ADD_SUB_EN
  assign cin_s = sub;
`else
  assign cin_s = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so the inversion is folded in at load time.
  assign b_load_s = b ^ {WIDTH{cin_s}};
  assign res_nxt  = {s0_s, res_r};

  bit_full_adder u_cell (
    .a   (a_sh_r[0]),
    .b   (b_sh_r[0]),
    .cin (carry_r),
    .s1  (s1_s),
    .s0  (s0_s)
  );

  // Next-state decode and load/finish strobes.
  always_comb begin
    state_nxt = state_r;
    load_s    = 1'b0;
    last_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          load_s    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (count_r == LAST_CNT) begin
          last_s    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          load_s    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath shift registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      res_r   <= {(WIDTH-1){1'b0}};
      count_r <= {CNT_W{1'b0}};
      carry_r <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= {(WIDTH+1){1'b0}};
    end else begin
      state_r <= state_nxt;
      ready   <= (state_nxt == S_IDLE) || (state_nxt == S_DONE);
      busy    <= (state_nxt == S_RUN);
      done    <= (state_nxt == S_DONE);
      if (load_s) begin
        a_sh_r  <= a;
        b_sh_r  <= b_load_s;
        res_r   <= {(WIDTH-1){1'b0}};
        count_r <= {CNT_W{1'b0}};
        carry_r <= cin_s;
      end else if (state_r == S_RUN) begin
        a_sh_r  <= a_sh_r >> 1;
        b_sh_r  <= b_sh_r >> 1;
        res_r   <= res_nxt[WIDTH-1:1];
        carry_r <= s1_s;
        // Hold at the last index so the counter never wraps.
        count_r <= last_s ? count_r : count_r + CNT_W'(1);
      end
      if (last_s) begin
        sum <= {s1_s, res_nxt};
      end
    end
  end

endmodule
